// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller.
// Optional feature macro: UART_RX_PARITY_DROP_EN (drop bytes that fail parity).
package uart_pkg;

  localparam int unsigned DIV_W    = 12;
  localparam logic [11:0] DIV_MIN  = 12'd4;
  localparam int unsigned HOLD_CYC = 2;
  localparam int unsigned DATA_W   = 8;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic              perr;
    logic [DATA_W-1:0] data;
  } rx_entry_t;

`ifdef UART_RX_PARITY_DROP_EN
  localparam int unsigned ENTRY_W = DATA_W;
`else
  localparam int unsigned ENTRY_W = $bits(rx_entry_t);
`endif

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver-side and host-side signals of the UART receive controller.
interface uart_rx_ctrl_if
  import uart_pkg::*;
#(
  parameter int unsigned LVL_W = 5
);
  logic              RX_READY;
  logic [DATA_W-1:0] RX_DATA;
  logic              RX_PARITY_OK;
  logic              RX_RST;
  logic [DIV_W-1:0]  WORK_FR;
  logic              CFG_WR;
  logic [DIV_W-1:0]  CFG_DIV;
  logic              POP;
  logic [DATA_W-1:0] RD_DATA;
  logic              RD_PERR;
  logic              EMPTY;
  logic              FULL;
  logic [LVL_W-1:0]  LEVEL;
  logic              CLR_ERR;
  logic              OVERRUN;
  logic              PARITY_ERR;
  logic              TIMEOUT;

  // Driver side: receiver model plus host.
  modport master (
    output RX_READY, RX_DATA, RX_PARITY_OK, CFG_WR, CFG_DIV, POP, CLR_ERR,
    input  RX_RST, WORK_FR, RD_DATA, RD_PERR, EMPTY, FULL, LEVEL,
           OVERRUN, PARITY_ERR, TIMEOUT
  );

  // Controller side.
  modport slave (
    input  RX_READY, RX_DATA, RX_PARITY_OK, CFG_WR, CFG_DIV, POP, CLR_ERR,
    output RX_RST, WORK_FR, RD_DATA, RD_PERR, EMPTY, FULL, LEVEL,
           OVERRUN, PARITY_ERR, TIMEOUT
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received bytes.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 9
) (
  input  logic                       PCLK,
  input  logic                       RESET,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Pop only when data exists; push when room exists or the head leaves this cycle.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != LVL_W'(DEPTH)) || w_do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + LVL_W'(1);
        2'b01:   r_count <= r_count - LVL_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset since the head is masked when empty.
  always_ff @(posedge PCLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == LVL_W'(DEPTH));
  assign o_level = r_count;
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: divisor ownership, receiver hold, byte FIFO, sticky status.
// Optional feature macro: UART_RX_PARITY_DROP_EN (drop bytes that fail parity).
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned      DEPTH       = 16,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 12'd867,
  parameter int unsigned      IDLE_BITS   = 40
) (
  input  logic         PCLK,
  input  logic         RESET,
  uart_rx_ctrl_if.slave bus
);
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
  localparam int unsigned IDLE_W = $clog2(IDLE_BITS + 1);

  state_e             r_state, w_state_nxt;
  logic               r_hold_cnt, w_hold_cnt_nxt;
  logic               r_rx_rst, w_rx_rst_nxt;
  logic [DIV_W-1:0]   r_work_fr;
  logic [DIV_W-1:0]   r_tick;
  logic [IDLE_W-1:0]  r_idle;
  logic               r_overrun, r_parity_err, r_timeout;
  logic               w_accept, w_push_req, w_tick, w_clr_timer;
  logic               w_full, w_empty;
  logic [LVL_W-1:0]   w_level;
  logic [ENTRY_W-1:0] w_wdata, w_rdata;
  logic               w_ovr_set, w_perr_set, w_to_set;

  assign w_accept    = bus.RX_READY && (r_state == ST_RUN);
  assign w_clr_timer = w_accept || bus.CFG_WR;

  // State register for the hold/run machine.
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      r_state    <= ST_HOLD;
      r_hold_cnt <= 1'b0;
      r_rx_rst   <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_rx_rst   <= w_rx_rst_nxt;
    end
  end

  // Next state: hold the receiver for HOLD_CYC cycles; a divisor write restarts the hold.
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_rx_rst_nxt   = 1'b0;
    case (r_state)
      ST_HOLD: begin
        if (r_hold_cnt == 1'(HOLD_CYC - 1)) begin
          w_state_nxt    = ST_RUN;
          w_hold_cnt_nxt = 1'b0;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_HOLD;
    endcase
    if (bus.CFG_WR) begin
      w_state_nxt    = ST_HOLD;
      w_hold_cnt_nxt = 1'b0;
    end
    w_rx_rst_nxt = (w_state_nxt == ST_HOLD);
  end

  // Divisor register with a floor so the receiver always has a usable bit period.
  always_ff @(posedge PCLK) begin
    if (RESET)           r_work_fr <= DEFAULT_DIV;
    else if (bus.CFG_WR) r_work_fr <= (bus.CFG_DIV < DIV_MIN) ? DIV_MIN : bus.CFG_DIV;
  end

  assign w_tick = (r_tick >= r_work_fr);

  // Bit-period tick and saturating idle counter, both restarted by activity.
  always_ff @(posedge PCLK) begin
    if (RESET || w_clr_timer) begin
      r_tick <= '0;
      r_idle <= '0;
    end else begin
      r_tick <= w_tick ? '0 : r_tick + DIV_W'(1);
      if (w_tick && (r_idle != IDLE_W'(IDLE_BITS))) r_idle <= r_idle + IDLE_W'(1);
    end
  end

`ifdef UART_RX_PARITY_DROP_EN
  assign w_push_req  = w_accept && bus.RX_PARITY_OK;
  assign w_wdata     = bus.RX_DATA;
  assign bus.RD_DATA = w_rdata;
  assign bus.RD_PERR = 1'b0;
`else
  rx_entry_t w_entry_in, w_entry_out;
  assign w_push_req  = w_accept;
  assign w_entry_in  = '{perr: !bus.RX_PARITY_OK, data: bus.RX_DATA};
  assign w_wdata     = w_entry_in;
  assign w_entry_out = rx_entry_t'(w_rdata);
  assign bus.RD_DATA = w_entry_out.data;
  assign bus.RD_PERR = w_entry_out.perr;
`endif

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .PCLK    (PCLK),
    .RESET   (RESET),
    .i_push  (w_push_req),
    .i_pop   (bus.POP),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign w_ovr_set  = w_push_req && w_full && !bus.POP;
  assign w_perr_set = w_accept && !bus.RX_PARITY_OK;
  assign w_to_set   = w_tick && !w_clr_timer && !w_empty
                      && (r_idle == IDLE_W'(IDLE_BITS - 1));

  // Sticky status flags; a set in the same cycle as a clear takes priority.
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      r_overrun    <= 1'b0;
      r_parity_err <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_overrun    <= w_ovr_set  || (r_overrun    && !bus.CLR_ERR);
      r_parity_err <= w_perr_set || (r_parity_err && !bus.CLR_ERR);
      r_timeout    <= w_to_set   || (r_timeout    && !bus.CLR_ERR && !bus.POP);
    end
  end

  assign bus.RX_RST     = r_rx_rst | RESET;
  assign bus.WORK_FR    = r_work_fr;
  assign bus.EMPTY      = w_empty;
  assign bus.FULL       = w_full;
  assign bus.LEVEL      = w_level;
  assign bus.OVERRUN    = r_overrun;
  assign bus.PARITY_ERR = r_parity_err;
  assign bus.TIMEOUT    = r_timeout;

endmodule
